// File: rtl/dram_arb.sv
// dram_arb: two-requester round-robin DRAM read arbiter with an in-order
// tag FIFO for read returns, plus an always-granted registered write path.
// Ports: clk/srstn; rd_req/rd_addr0/rd_addr1 -> rd_gnt/rd_valid/rd_data;
//   wr_req/wr_addr/wr_data -> wr_gnt; dram_en_rd/dram_addr_rd,
//   dram_valid/dram_data_rd, dram_en_wr/dram_addr_wr/dram_data_wr;
//   busy, err (sticky), perf_stall.
// Option: DRAM_ARB_PERF_EN enables the saturating read-stall counter.
module dram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic [1:0]            rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [1:0]            rd_gnt,
  output logic [1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] dram_addr_rd,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] dram_data_rd,
  output logic                  dram_en_wr,
  output logic [ADDR_WIDTH-1:0] dram_addr_wr,
  output logic [DATA_WIDTH-1:0] dram_data_wr,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           perf_stall
);

  localparam int PW =
    (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [TAG_DEPTH-1:0] tag_q;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 last;

  logic full;
  logic empty;
  logic can_gnt;
  logic push;
  logic pop;
  logic gnt_id;
  logic head_id;
  logic err_set;

  assign full  = (count == CW'(TAG_DEPTH));
  assign empty = (count == '0);

  // A full FIFO may still grant when a return frees a slot this cycle.
  assign can_gnt = srstn & (~full | dram_valid);

  always_comb begin
    rd_gnt = 2'b00;
    if (can_gnt) begin
      unique case (rd_req)
        2'b01:   rd_gnt = 2'b01;
        2'b10:   rd_gnt = 2'b10;
        2'b11:   rd_gnt = last ? 2'b01 : 2'b10;
        default: rd_gnt = 2'b00;
      endcase
    end
  end

  assign push   = |rd_gnt;
  assign gnt_id = rd_gnt[1];

  // With an empty FIFO a same-cycle push is returned straight through.
  assign head_id = empty ? gnt_id : tag_q[rd_ptr];
  assign pop     = srstn & dram_valid & (~empty | push);
  assign err_set = srstn & dram_valid & empty & ~push;

  always_comb begin
    rd_valid = 2'b00;
    if (pop) begin
      rd_valid = head_id ? 2'b10 : 2'b01;
    end
  end

  assign rd_data = srstn ? dram_data_rd : '0;
  assign wr_gnt  = wr_req;
  assign busy    = ~empty | dram_en_rd | dram_en_wr;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      tag_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= 1'b1;
      err    <= 1'b0;
    end else begin
      if (push) begin
        tag_q[wr_ptr] <= gnt_id;
        wr_ptr        <= wr_ptr + PW'(1);
        last          <= gnt_id;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      dram_en_rd   <= 1'b0;
      dram_addr_rd <= '0;
    end else begin
      dram_en_rd <= push;
      if (push) begin
        dram_addr_rd <= gnt_id ? rd_addr1 : rd_addr0;
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      dram_en_wr   <= 1'b0;
      dram_addr_wr <= '0;
      dram_data_wr <= '0;
    end else begin
      dram_en_wr <= wr_req;
      if (wr_req) begin
        dram_addr_wr <= wr_addr;
        dram_data_wr <= wr_data;
      end
    end
  end

`ifdef DRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      perf_stall <= '0;
    end else if ((|rd_req) && !push &&
                 (perf_stall != 16'hFFFF)) begin
      perf_stall <= perf_stall + 16'd1;
    end
  end
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_dram_arb.sv
// tb_dram_arb: directed scoreboard bench for dram_arb.
// Read tags are queued at grant time and popped on each DRAM return.
module tb_dram_arb;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int TD = 4;

`ifdef DRAM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          srstn = 1'b0;
  logic [1:0]    rd_req = '0;
  logic [AW-1:0] rd_addr0 = '0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [1:0]    rd_gnt;
  logic [1:0]    rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic          dram_en_rd;
  logic [AW-1:0] dram_addr_rd;
  logic          dram_valid = 1'b0;
  logic [DW-1:0] dram_data_rd = '0;
  logic          dram_en_wr;
  logic [AW-1:0] dram_addr_wr;
  logic [DW-1:0] dram_data_wr;
  logic          busy;
  logic          err;
  logic [15:0]   perf_stall;

  dram_arb #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TAG_DEPTH (TD)
  ) dut (
    .clk         (clk),
    .srstn       (srstn),
    .rd_req      (rd_req),
    .rd_addr0    (rd_addr0),
    .rd_addr1    (rd_addr1),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .dram_en_rd  (dram_en_rd),
    .dram_addr_rd(dram_addr_rd),
    .dram_valid  (dram_valid),
    .dram_data_rd(dram_data_rd),
    .dram_en_wr  (dram_en_wr),
    .dram_addr_wr(dram_addr_wr),
    .dram_data_wr(dram_data_wr),
    .busy        (busy),
    .err         (err),
    .perf_stall  (perf_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit q[$];
  int stall_exp = 0;
  logic err_exp = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs,
  // then check registered outputs just after the rising edge.
  task automatic cyc(input logic [1:0]  req,
                     input logic [1:0]  eg,
                     input logic        dv,
                     input logic [31:0] dd,
                     input logic        wr);
    logic [AW-1:0] ea;
    logic [1:0]    ev;
    @(negedge clk);
    rd_req       = req;
    dram_valid   = dv;
    dram_data_rd = dd;
    wr_req       = wr;
    #1;
    chk("rd_gnt", 64'(rd_gnt), 64'(eg));
    chk("wr_gnt", 64'(wr_gnt), 64'(wr));
    ea = eg[1] ? rd_addr1 : rd_addr0;
    if (eg != 2'b00) q.push_back(eg[1]);
    if (req != 2'b00 && eg == 2'b00) stall_exp++;
    ev = 2'b00;
    if (dv) begin
      if (q.size() > 0) begin
        ev = q.pop_front() ? 2'b10 : 2'b01;
        chk("rd_data", 64'(rd_data), 64'(dd));
      end else begin
        err_exp = 1'b1;
      end
    end
    chk("rd_valid", 64'(rd_valid), 64'(ev));
    @(posedge clk);
    #1;
    chk("en_rd", 64'(dram_en_rd), 64'(eg != 2'b00));
    if (eg != 2'b00)
      chk("addr_rd", 64'(dram_addr_rd), 64'(ea));
    chk("en_wr", 64'(dram_en_wr), 64'(wr));
    if (wr) begin
      chk("addr_wr", 64'(dram_addr_wr), 64'(wr_addr));
      chk("data_wr", 64'(dram_data_wr), 64'(wr_data));
    end
    chk("err", 64'(err), 64'(err_exp));
    chk("busy", 64'(busy),
        64'(q.size() != 0 || eg != 2'b00 || wr));
    chk("perf", 64'(perf_stall),
        64'(PERF ? stall_exp : 0));
  endtask

  // Assert reset with busy inputs, check every output, release
  // at the next falling edge.
  task automatic rst_chk();
    srstn        = 1'b0;
    rd_req       = 2'b11;
    dram_valid   = 1'b1;
    dram_data_rd = 32'h1;
    wr_req       = 1'b1;
    #1;
    chk("rst_gnt", 64'(rd_gnt), 64'(0));
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_en_rd", 64'(dram_en_rd), 64'(0));
    chk("rst_en_wr", 64'(dram_en_wr), 64'(0));
    chk("rst_addr_rd", 64'(dram_addr_rd), 64'(0));
    chk("rst_addr_wr", 64'(dram_addr_wr), 64'(0));
    chk("rst_data_wr", 64'(dram_data_wr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_perf", 64'(perf_stall), 64'(0));
    @(negedge clk);
    srstn      = 1'b1;
    rd_req     = 2'b00;
    dram_valid = 1'b0;
    wr_req     = 1'b0;
    q.delete();
    err_exp   = 1'b0;
    stall_exp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_chk();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rd_addr0 = 18'h00123;
    rd_addr1 = 18'h3ABCD;
    do_reset();

    // Contention alternates 0,1,0,1; returns two cycles after strobes.
    cyc(2'b11, 2'b01, 1'b0, 32'h0, 1'b0);
    cyc(2'b11, 2'b10, 1'b0, 32'h0, 1'b0);
    cyc(2'b11, 2'b01, 1'b0, 32'h0, 1'b0);
    cyc(2'b11, 2'b10, 1'b1, 32'hA000_0000, 1'b0);
    cyc(2'b00, 2'b00, 1'b1, 32'hA000_0001, 1'b0);
    cyc(2'b00, 2'b00, 1'b1, 32'hA000_0002, 1'b0);
    cyc(2'b00, 2'b00, 1'b1, 32'hA000_0003, 1'b0);

    // Fill to depth, stall, then a return frees one grant.
    for (int i = 0; i < TD; i++)
      cyc(2'b01, 2'b01, 1'b0, 32'h0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 32'h0, 1'b0);
    cyc(2'b01, 2'b00, 1'b0, 32'h0, 1'b0);
    cyc(2'b01, 2'b01, 1'b1, 32'hB000_0001, 1'b0);
    for (int i = 0; i < TD; i++)
      cyc(2'b00, 2'b00, 1'b1, 32'hC000_0000 + i, 1'b0);

    // Empty FIFO: push and return in the same cycle.
    cyc(2'b10, 2'b10, 1'b1, 32'h5555_AAAA, 1'b0);

    // Write together with a read; then write regs hold.
    wr_addr = 18'h20000;
    wr_data = 32'hDEADBEEF;
    cyc(2'b11, 2'b01, 1'b0, 32'h0, 1'b1);
    cyc(2'b00, 2'b00, 1'b1, 32'h0000_1234, 1'b0);
    chk("hold_addr_wr", 64'(dram_addr_wr), 64'(18'h20000));
    chk("hold_data_wr", 64'(dram_data_wr), 64'(32'hDEADBEEF));
    cyc(2'b11, 2'b10, 1'b1, 32'h0000_0077, 1'b0);

    // Spurious return after reset: error, sticky.
    do_reset();
    cyc(2'b00, 2'b00, 1'b1, 32'h0000_0BAD, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 32'h0, 1'b0);

    // Two reads outstanding, reset mid-cycle, late return errors.
    do_reset();
    cyc(2'b11, 2'b01, 1'b0, 32'h0, 1'b0);
    cyc(2'b11, 2'b10, 1'b0, 32'h0, 1'b0);
    #3;
    rst_chk();
    cyc(2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
    cyc(2'b00, 2'b00, 1'b1, 32'h0000_F00D, 1'b0);

    // Stall counter: full FIFO with a held request for 10 cycles.
    do_reset();
    for (int i = 0; i < TD; i++)
      cyc(2'b01, 2'b01, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(2'b01, 2'b00, 1'b0, 32'h0, 1'b0);
    chk("perf_10", 64'(perf_stall), 64'(PERF ? 10 : 0));
    for (int i = 0; i < TD; i++)
      cyc(2'b00, 2'b00, 1'b1, 32'hD000_0000 + i, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
